// File: rtl/speed_pkg.sv
// Shared types and default constants for the speed-check session controller.
package speed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int TICK_DIV_DEF   = 100_000_000;
  localparam int WINDOW_SEC_DEF = 10;
  localparam int THRESHOLD_DEF  = 33;
  localparam int PASS_MAX_DEF   = 9;
  localparam int CNT_W_DEF      = 9;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge detect for a raw sensor input.
module pulse_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic evt_o
);

  logic s1_q, s2_q, s3_q, evt_q;

  // Edge strobe is registered so sensor-to-event latency is exactly three clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      evt_q <= 1'b0;
    end else begin
      s1_q  <= sig_i;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      evt_q <= s2_q & ~s3_q;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/speed_session_ctrl.sv
// Timed speed-check session: per-second tick, pulse counting and qualifying-second tally.
module speed_session_ctrl
  import speed_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int WINDOW_SEC = WINDOW_SEC_DEF,
  parameter int THRESHOLD  = THRESHOLD_DEF,
  parameter int PASS_MAX   = PASS_MAX_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             pulse_in,
  output logic             busy,
  output logic             done,
  output logic             sec_tick,
  output logic [4:0]       elapsed,
  output logic [CNT_W-1:0] pulse_count,
  output logic [15:0]      pass_count
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [4:0]      WIN       = 5'(WINDOW_SEC);
  localparam logic [15:0]     PMAX      = 16'(PASS_MAX);

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic [4:0]       el_q, el_d;
  logic [CNT_W-1:0] pc_q, pc_d;
  logic [15:0]      pass_q, pass_d;
  logic             pulse_evt;
  logic [CNT_W:0]   eff_raw;
  logic [CNT_W-1:0] eff;

  pulse_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .sig_i (pulse_in),
    .evt_o (pulse_evt)
  );

  // An event landing on the tick still belongs to the second that is ending.
  assign eff_raw = {1'b0, pc_q} + (CNT_W+1)'(pulse_evt);
  assign eff     = eff_raw[CNT_W] ? CNT_MAX : eff_raw[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    el_d    = el_q;
    pc_d    = pc_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        presc_d = '0;
        if (start) begin
          state_d = RUN;
          el_d    = '0;
          pc_d    = '0;
          pass_d  = '0;
        end
      end
      RUN: begin
        if (tick_q) begin
          presc_d = '0;
          pc_d    = '0;
          el_d    = el_q + 5'd1;
          if (32'(eff) >= 32'(THRESHOLD) && pass_q < PMAX) pass_d = pass_q + 16'd1;
          if (el_q + 5'd1 == WIN) state_d = DONE;
        end else begin
          presc_d = presc_q + PW'(1);
          if (pulse_evt && pc_q != CNT_MAX) pc_d = pc_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      presc_d = '0;
      el_d    = '0;
      pc_d    = '0;
      pass_d  = '0;
    end
    // Registered strobe: high in exactly the cycle the prescaler sits at its last count.
    tick_d = (state_d == RUN) && (presc_d == TICK_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      el_q    <= '0;
      pc_q    <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      el_q    <= el_d;
      pc_q    <= pc_d;
      pass_q  <= pass_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign sec_tick    = tick_q;
  assign elapsed     = el_q;
  assign pulse_count = pc_q;
  assign pass_count  = pass_q;

endmodule

// File: tb/tb_speed_session_ctrl.sv
// Directed bench: two controllers share all inputs and differ only in PASS_MAX (2 and 1).
module tb_speed_session_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic clear = 1'b0;
  logic pulse_in = 1'b0;

  logic busy_a, done_a, tick_a, busy_b, done_b, tick_b;
  logic [4:0]  el_a, el_b;
  logic [8:0]  pc_a, pc_b;
  logic [15:0] pass_a, pass_b;

  int checks = 0;
  int errors = 0;

  speed_session_ctrl #(.TICK_DIV(10), .WINDOW_SEC(3), .THRESHOLD(3), .PASS_MAX(2), .CNT_W(9)) dut_a (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .pulse_in(pulse_in),
    .busy(busy_a), .done(done_a), .sec_tick(tick_a), .elapsed(el_a),
    .pulse_count(pc_a), .pass_count(pass_a)
  );

  speed_session_ctrl #(.TICK_DIV(10), .WINDOW_SEC(3), .THRESHOLD(3), .PASS_MAX(1), .CNT_W(9)) dut_b (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .pulse_in(pulse_in),
    .busy(busy_b), .done(done_b), .sec_tick(tick_b), .elapsed(el_b),
    .pulse_count(pc_b), .pass_count(pass_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Nine cycles; slot i drives a one-cycle pulse at offset 2*i, counted 4 cycles later.
  task automatic drive_second(input logic [4:0] m);
    for (int i = 0; i < 5; i++) begin
      pulse_in = m[i];
      cyc();
      pulse_in = 1'b0;
      if (i < 4) cyc();
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int bad;
    cyc();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    reset = 1'b0;

    // Idle with a toggling sensor: nothing may move
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      pulse_in = ~pulse_in;
      cyc();
      if (busy_a || done_a || tick_a || (|el_a) || (|pc_a) || (|pass_a)) bad++;
    end
    pulse_in = 1'b0;
    repeat (5) cyc();
    chk("idle_quiet", bad, 0);

    // Session 4/2/3 pulses
    do_start();
    chk("run_busy", busy_a, 1);
    chk("run_el0", el_a, 0);
    drive_second(5'b01111);
    chk("s1_tick", tick_a, 1);
    chk("s1_pc_pre", pc_a, 3);
    cyc();
    chk("s1_el", el_a, 1);
    chk("s1_pass", pass_a, 1);
    chk("s1_pc_clr", pc_a, 0);
    chk("s1_tick_off", tick_a, 0);
    drive_second(5'b00011);
    chk("s2_pc_pre", pc_a, 2);
    cyc();
    chk("s2_pass", pass_a, 1);
    chk("s2_el", el_a, 2);
    drive_second(5'b00111);
    chk("s3_pc_pre", pc_a, 3);
    chk("s3_busy_pre", busy_a, 1);
    cyc();
    chk("s3_pass", pass_a, 2);
    chk("s3_el", el_a, 3);
    chk("s3_done", done_a, 1);
    chk("s3_busy", busy_a, 0);
    chk("s3_pass_b", pass_b, 1);

    // DONE holds and ignores pulses
    drive_second(5'b11111);
    repeat (4) cyc();
    chk("done_pc", pc_a, 0);
    chk("done_pass", pass_a, 2);
    chk("done_el", el_a, 3);
    chk("done_tick", tick_a, 0);
    start = 1'b1;
    clear = 1'b1;
    cyc();
    start = 1'b0;
    clear = 1'b0;
    chk("clr_prio_busy", busy_a, 0);
    chk("clr_prio_done", done_a, 0);

    // Saturation: dense pulses every second
    do_start();
    chk("sat_pass0", pass_a, 0);
    drive_second(5'b11111);
    cyc();
    chk("sat1_a", pass_a, 1);
    chk("sat1_b", pass_b, 1);
    drive_second(5'b11111);
    cyc();
    chk("sat2_a", pass_a, 2);
    chk("sat2_b", pass_b, 1);
    drive_second(5'b11111);
    cyc();
    chk("sat3_a", pass_a, 2);
    chk("sat3_b", pass_b, 1);
    chk("sat3_el", el_b, 3);
    chk("sat3_done", done_b, 1);
    repeat (4) cyc();

    // Pulse coincident with the tick, two earlier
    do_start();
    drive_second(5'b01011);
    chk("co_tick", tick_a, 1);
    chk("co_pc_pre", pc_a, 2);
    cyc();
    chk("co_pass", pass_a, 1);
    chk("co_pc_clr", pc_a, 0);

    // Clear mid second 2, then a fresh session
    pulse_in = 1'b1;
    cyc();
    pulse_in = 1'b0;
    repeat (4) cyc();
    chk("mid_pc", pc_a, 1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_busy", busy_a, 0);
    chk("clr_el", el_a, 0);
    chk("clr_pass", pass_a, 0);
    chk("clr_pc", pc_a, 0);
    repeat (3) cyc();
    do_start();
    repeat (8) cyc();
    chk("fresh_tick_early", tick_a, 0);
    cyc();
    chk("fresh_tick", tick_a, 1);
    cyc();
    chk("fresh_el", el_a, 1);
    chk("fresh_pass", pass_a, 0);

    // Async reset mid-RUN, between edges
    repeat (3) cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", busy_a, 0);
    chk("arst_el", el_a, 0);
    chk("arst_tick", tick_a, 0);
    #2;
    reset = 1'b0;
    cyc();
    do_start();
    drive_second(5'b00111);
    chk("post_tick", tick_a, 1);
    chk("post_pc", pc_a, 3);
    cyc();
    chk("post_el", el_a, 1);
    chk("post_pass", pass_a, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
